lfsr_decrypt_ctrl: RTL and testbench

LFSR_DECRYPT_CTRL -- requirements
Module: lfsr_decrypt_ctrl

---
 rtl/lfsr_decrypt_ctrl.sv | 115 +++++++++++
 tb/tb_lfsr_decrypt_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl: identifies the LFSR tap used to encrypt a message from its 8'h7E preamble, then decrypts the payload
//   clk, rst (async, active-high)          clock and reset
//   start                                  begin a run (accepted only in IDLE/DONE/FAIL)
//   mem_rdata / mem_raddr                  combinational encrypted-byte read port
//   mem_waddr / mem_wr_en / mem_wdata      decrypted-byte write port
//   lfsr_states                            six external 5-bit LFSR states, tap i at [5i+4:5i]
//   lfsr_load / lfsr_seed / lfsr_en        LFSR control
//   tap_sel                                index of the identified tap
//   busy / done / error                    run status
module lfsr_decrypt_ctrl #(
    parameter int SRC_BASE = 128,
    parameter int DST_BASE = 192,
    parameter int MSG_LEN  = 64,
    parameter int PRE_LEN  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  mem_rdata,
    input  logic [29:0] lfsr_states,
    output logic [7:0]  mem_raddr,
    output logic [7:0]  mem_waddr,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    output logic        lfsr_load,
    output logic        lfsr_en,
    output logic [4:0]  lfsr_seed,
    output logic [2:0]  tap_sel,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, SEED, STEP, TRAIN, RESOLVE, DECRYPT, DONE, FAIL} state_t;
    localparam logic [7:0] SRC = 8'(SRC_BASE);
    localparam logic [7:0] DST = 8'(DST_BASE);
    localparam logic [7:0] TRAIN_LAST = 8'(PRE_LEN - 2);
    localparam logic [7:0] DEC_LAST = 8'(MSG_LEN - PRE_LEN - 1);
    state_t state, state_n;
    logic [7:0] rd_ptr, wr_ptr, cnt;
    logic [5:0] match_mask, hit;
    logic [4:0] st [8];
    logic [2:0] low;
    logic       idle_like;
    always_comb begin
        for (int i = 0; i < 6; i++) st[i] = lfsr_states[5*i +: 5];
        st[6] = 5'd0;
        st[7] = 5'd0;
        for (int i = 0; i < 6; i++) hit[i] = {mem_rdata[7:5], mem_rdata[4:0] ^ st[i]} == 8'h7E;
        low = 3'd0;
        for (int i = 5; i >= 0; i--) if (match_mask[i]) low = 3'(i);
    end
    assign idle_like = (state == IDLE) || (state == DONE) || (state == FAIL);
    assign busy      = !idle_like;
    assign done      = (state == DONE) || (state == FAIL);
    assign error     = state == FAIL;
    assign mem_raddr = rd_ptr;
    assign mem_waddr = wr_ptr;
    assign mem_wr_en = state == DECRYPT;
    assign mem_wdata = {mem_rdata[7:5], mem_rdata[4:0] ^ st[tap_sel]};
    assign lfsr_load = state == SEED;
    // preamble byte 0 is plaintext 8'h7E, so its low bits undo to the seed
    assign lfsr_seed = lfsr_load ? (mem_rdata[4:0] ^ 5'h1E) : 5'd0;
    assign lfsr_en   = (state == STEP) || (state == TRAIN) || (state == DECRYPT);
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, FAIL: state_n = start ? SEED : state;
            SEED:    state_n = STEP;
            STEP:    state_n = TRAIN;
            TRAIN:   state_n = (cnt == TRAIN_LAST) ? RESOLVE : TRAIN;
            RESOLVE: state_n = (match_mask == 6'd0) ? FAIL : DECRYPT;
            DECRYPT: state_n = (cnt == DEC_LAST) ? DONE : DECRYPT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= SRC;
            wr_ptr     <= DST;
            match_mask <= 6'h3F;
            tap_sel    <= 3'd0;
            cnt        <= 8'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE, FAIL: if (start) begin
                    match_mask <= 6'h3F;
                    rd_ptr     <= SRC;
                    wr_ptr     <= DST;
                    cnt        <= 8'd0;
                end
                STEP: begin
                    rd_ptr <= SRC + 8'd1;
                    cnt    <= 8'd0;
                end
                TRAIN: begin
                    rd_ptr     <= rd_ptr + 8'd1;
                    match_mask <= match_mask & hit;
                    cnt        <= cnt + 8'd1;
                end
                RESOLVE: begin
                    if (match_mask != 6'd0) tap_sel <= low;
                    cnt <= 8'd0;
                end
                DECRYPT: begin
                    rd_ptr <= rd_ptr + 8'd1;
                    wr_ptr <= wr_ptr + 8'd1;
                    cnt    <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// tb_lfsr_decrypt_ctrl: directed bench with external LFSR and memory models for two parameterisations
module tb_lfsr_decrypt_ctrl;
    localparam int SB[2] = '{128, 200};
    localparam int DB[2] = '{192, 240};
    localparam int ML[2] = '{64, 56};
    localparam int PL = 5;
    localparam logic [4:0] TAPS[6] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};
    logic clk = 1'b0;
    logic rst;
    logic start [2];
    logic [7:0] rdata [2], raddr [2], waddr [2], wdata [2];
    logic wr_en [2], load [2], en [2], busy [2], done [2], error [2];
    logic [4:0] seed [2];
    logic [2:0] tap_sel [2];
    logic [29:0] states [2];
    logic [7:0] src [2][256];
    logic [7:0] expw [2][256];
    logic [4:0] ls [2][6];
    logic [7:0] lastw [2];
    int wcnt [2], bad [2];
    int oob;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    lfsr_decrypt_ctrl u0 (
        .clk(clk), .rst(rst), .start(start[0]), .mem_rdata(rdata[0]), .lfsr_states(states[0]),
        .mem_raddr(raddr[0]), .mem_waddr(waddr[0]), .mem_wr_en(wr_en[0]), .mem_wdata(wdata[0]),
        .lfsr_load(load[0]), .lfsr_en(en[0]), .lfsr_seed(seed[0]), .tap_sel(tap_sel[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]));
    lfsr_decrypt_ctrl #(.SRC_BASE(200), .DST_BASE(240), .MSG_LEN(56), .PRE_LEN(5)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .mem_rdata(rdata[1]), .lfsr_states(states[1]),
        .mem_raddr(raddr[1]), .mem_waddr(waddr[1]), .mem_wr_en(wr_en[1]), .mem_wdata(wdata[1]),
        .lfsr_load(load[1]), .lfsr_en(en[1]), .lfsr_seed(seed[1]), .tap_sel(tap_sel[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]));
    function automatic logic [4:0] nxt(input logic [4:0] s, input logic [4:0] t);
        return {s[3:0], 1'b0} ^ (s[4] ? t : 5'd0);
    endfunction
    assign rdata[0] = src[0][raddr[0]];
    assign rdata[1] = src[1][raddr[1]];
    always_comb
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 6; i++) states[d][5*i +: 5] = ls[d][i];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++)
                if (load[d]) ls[d][i] <= seed[d];
                else if (en[d]) ls[d][i] <= nxt(ls[d][i], TAPS[i]);
            if (wr_en[d]) begin
                wcnt[d] <= wcnt[d] + 1;
                lastw[d] <= waddr[d];
                if (wdata[d] !== expw[d][waddr[d]]) bad[d] <= bad[d] + 1;
            end
        end
        if (busy[1] && raddr[1] < 8'd200) oob <= oob + 1;
    end
    task automatic prepare(input int d, input int tap, input bit corrupt);
        logic [4:0] s;
        logic [7:0] p, e;
        s = 5'h07;
        for (int k = 0; k < ML[d]; k++) begin
            p = (k < PL) ? 8'h7E : 8'($urandom);
            e = {p[7:5], p[4:0] ^ s};
            if (corrupt && k == 3) e[7] = ~e[7];
            src[d][(SB[d] + k) % 256] = e;
            if (k >= PL) expw[d][(DB[d] + k - PL) % 256] = p;
            s = nxt(s, TAPS[tap]);
        end
    endtask
    task automatic wait_done(input int d, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (done[d]) break;
            if (cyc >= 300) begin
                checks++; errors++;
                $display("FAIL timeout dut%0d: done not seen after %0d edges", d, cyc);
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask
    task automatic run(input int d, output int cyc);
        @(negedge clk); start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        wait_done(d, cyc);
    endtask
    task automatic check_run(input string nm, input int d, input int cyc, input int w0, input int b0, input int tap, input logic [7:0] last);
        checks++; if (cyc !== ML[d] + 2) begin errors++; $display("FAIL %s latency got %0d exp %0d", nm, cyc, ML[d] + 2); end
        checks++; if (tap_sel[d] !== 3'(tap)) begin errors++; $display("FAIL %s tap_sel got %0d exp %0d", nm, tap_sel[d], tap); end
        checks++; if (error[d] !== 1'b0 || busy[d] !== 1'b0) begin errors++; $display("FAIL %s error/busy got %b/%b exp 0/0", nm, error[d], busy[d]); end
        checks++; if (wcnt[d] - w0 !== ML[d] - PL) begin errors++; $display("FAIL %s writes got %0d exp %0d", nm, wcnt[d] - w0, ML[d] - PL); end
        checks++; if (bad[d] - b0 !== 0) begin errors++; $display("FAIL %s bad data got %0d exp 0", nm, bad[d] - b0); end
        checks++; if (lastw[d] !== last) begin errors++; $display("FAIL %s last waddr got %0d exp %0d", nm, lastw[d], last); end
    endtask
    task automatic test_reset();
        rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
        #1;
        checks++; if ({done[0], error[0], busy[0], wr_en[0], load[0], en[0]} !== 6'b0) begin errors++; $display("FAIL reset flags got %b exp 000000", {done[0], error[0], busy[0], wr_en[0], load[0], en[0]}); end
        checks++; if (tap_sel[0] !== 3'd0 || seed[0] !== 5'd0) begin errors++; $display("FAIL reset tap_sel/seed got %0d/%0d exp 0/0", tap_sel[0], seed[0]); end
        checks++; if (raddr[0] !== 8'd128 || waddr[0] !== 8'd192) begin errors++; $display("FAIL reset ptrs got %0d/%0d exp 128/192", raddr[0], waddr[0]); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL idle_hold busy/done got %b/%b exp 0/0", busy[0], done[0]); end
    endtask
    task automatic test_tap(input int tap, input string nm);
        int cyc, w0, b0;
        prepare(0, tap, 1'b0);
        w0 = wcnt[0]; b0 = bad[0];
        run(0, cyc);
        check_run(nm, 0, cyc, w0, b0, tap, 8'd250);
    endtask
    task automatic test_no_match();
        int cyc, w0;
        prepare(0, 2, 1'b1);
        w0 = wcnt[0];
        run(0, cyc);
        checks++; if (cyc !== PL + 2) begin errors++; $display("FAIL nomatch latency got %0d exp %0d", cyc, PL + 2); end
        checks++; if (error[0] !== 1'b1 || done[0] !== 1'b1) begin errors++; $display("FAIL nomatch error/done got %b/%b exp 1/1", error[0], done[0]); end
        checks++; if (wcnt[0] - w0 !== 0) begin errors++; $display("FAIL nomatch writes got %0d exp 0", wcnt[0] - w0); end
    endtask
    task automatic test_back_to_back();
        int cyc, w0, b0;
        prepare(0, 4, 1'b0);
        w0 = wcnt[0]; b0 = bad[0];
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk);
        wait_done(0, cyc);
        checks++; if (cyc !== 66) begin errors++; $display("FAIL held latency got %0d exp 66", cyc); end
        checks++; if (wcnt[0] - w0 !== 59) begin errors++; $display("FAIL held writes got %0d exp 59", wcnt[0] - w0); end
        @(posedge clk); #1;
        checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL held restart busy/done got %b/%b exp 1/0", busy[0], done[0]); end
        start[0] = 1'b0;
        wait_done(0, cyc);
        checks++; if (wcnt[0] - w0 !== 118 || bad[0] - b0 !== 0) begin errors++; $display("FAIL held second run writes/bad got %0d/%0d exp 118/0", wcnt[0] - w0, bad[0] - b0); end
    endtask
    task automatic test_reset_mid_run();
        int cyc, w0, n;
        prepare(0, 2, 1'b0);
        w0 = wcnt[0];
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        n = 0;
        while (wcnt[0] - w0 < 20 && n < 200) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        checks++; if ({busy[0], done[0], error[0], wr_en[0], load[0], en[0]} !== 6'b0) begin errors++; $display("FAIL midrst flags got %b exp 000000", {busy[0], done[0], error[0], wr_en[0], load[0], en[0]}); end
        checks++; if (raddr[0] !== 8'd128 || waddr[0] !== 8'd192 || tap_sel[0] !== 3'd0) begin errors++; $display("FAIL midrst ptrs/tap got %0d/%0d/%0d exp 128/192/0", raddr[0], waddr[0], tap_sel[0]); end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wcnt[0] - w0 !== 20 || busy[0] !== 1'b0) begin errors++; $display("FAIL midrst writes/busy got %0d/%b exp 20/0", wcnt[0] - w0, busy[0]); end
        test_tap(2, "after_rst");
    endtask
    task automatic test_wrap();
        int cyc, w0, b0, o0;
        prepare(1, 3, 1'b0);
        w0 = wcnt[1]; b0 = bad[1]; o0 = oob;
        run(1, cyc);
        check_run("wrap", 1, cyc, w0, b0, 3, 8'd34);
        checks++; if (oob - o0 !== 0) begin errors++; $display("FAIL wrap raddr below 200 got %0d times exp 0", oob - o0); end
    endtask
    initial begin
        test_reset();
        test_tap(2, "tap2");
        test_tap(5, "tap5");
        test_no_match();
        test_back_to_back();
        test_reset_mid_run();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end
endmodule
